// File: rtl/iterative_shift_unit.sv
// Multicycle shift unit: SLL/SRL/SRA/ROR one bit per clock with a start/busy/done handshake.
// 2**NBITS must equal WIDTH so any legal shift amount fits in the count register.
module iterative_shift_unit #(
  parameter int WIDTH = 32,
  parameter int NBITS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [NBITS-1:0] in_n,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  state_t           state, state_next;
  logic [NBITS-1:0] count, count_next;
  logic [1:0]       op_r, op_next;
  logic [WIDTH-1:0] out_next, shifted;

  always_comb begin
    case (op_r)
      OP_SLL:  shifted = {out[WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, out[WIDTH-1:1]};
      OP_SRA:  shifted = {out[WIDTH-1], out[WIDTH-1:1]};
      default: shifted = {out[0], out[WIDTH-1:1]};
    endcase
  end

  // Operands are captured only in IDLE; SHIFT and DONE ignore every input.
  always_comb begin
    state_next = state;
    count_next = count;
    op_next    = op_r;
    out_next   = out;
    case (state)
      IDLE: begin
        if (start) begin
          out_next   = in_data;
          count_next = in_n;
          op_next    = op;
          state_next = (in_n != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        out_next   = shifted;
        count_next = count - NBITS'(1);
        if (count == NBITS'(1)) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      out   <= '0;
      count <= '0;
      op_r  <= 2'b00;
    end else begin
      state <= state_next;
      out   <= out_next;
      count <= count_next;
      op_r  <= op_next;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Directed bench for iterative_shift_unit: results, latency, reset abort and start-while-busy.
module tb_iterative_shift_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] in_data;
  logic [4:0]  in_n;
  logic [31:0] out;
  logic        busy;
  logic        done;

  int n_compared = 0;
  int n_mismatch = 0;
  int lat;
  int busy_cnt;
  int done_cnt;

  iterative_shift_unit #(.WIDTH(32), .NBITS(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .in_data (in_data),
    .in_n    (in_n),
    .out     (out),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatch++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Returns at the first negedge after the start edge has been sampled.
  task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] d, input logic [4:0] n);
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    in_data = d;
    in_n    = n;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // lat counts negedges since the start edge, 1 being the first negedge after it.
  task automatic wait_done(input int base, output int latency, output int busy_seen);
    latency   = base;
    busy_seen = 0;
    while (1) begin
      if (busy) busy_seen++;
      if (done || latency >= 100) break;
      @(negedge clk);
      latency++;
    end
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    in_data = 32'h0;
    in_n    = 5'd0;

    #12;
    check_output("reset_out",  out,  32'h0);
    check_output("reset_busy", {31'b0, busy}, 32'h0);
    check_output("reset_done", {31'b0, done}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // SLL 1 by 4: done 5 edges after start, busy for 5 cycles
    apply_stimulus(2'b00, 32'h0000_0001, 5'd4);
    wait_done(1, lat, busy_cnt);
    check_output("sll4_latency", lat, 32'd5);
    check_output("sll4_busy_cycles", busy_cnt, 32'd5);
    check_output("sll4_out", out, 32'h0000_0010);
    @(negedge clk);
    check_output("sll4_idle_busy", {31'b0, busy}, 32'h0);
    check_output("sll4_idle_done", {31'b0, done}, 32'h0);
    check_output("sll4_out_held", out, 32'h0000_0010);

    apply_stimulus(2'b10, 32'hF000_0000, 5'd4);
    wait_done(1, lat, busy_cnt);
    check_output("sra4_latency", lat, 32'd5);
    check_output("sra4_out", out, 32'hFF00_0000);

    apply_stimulus(2'b01, 32'hF000_0000, 5'd4);
    wait_done(1, lat, busy_cnt);
    check_output("srl4_out", out, 32'h0F00_0000);

    apply_stimulus(2'b11, 32'h1234_5678, 5'd8);
    wait_done(1, lat, busy_cnt);
    check_output("ror8_latency", lat, 32'd9);
    check_output("ror8_out", out, 32'h7812_3456);

    apply_stimulus(2'b00, 32'h1234_5678, 5'd0);
    wait_done(1, lat, busy_cnt);
    check_output("n0_latency", lat, 32'd1);
    check_output("n0_out", out, 32'h1234_5678);

    apply_stimulus(2'b10, 32'h8000_0000, 5'd31);
    wait_done(1, lat, busy_cnt);
    check_output("sra31_latency", lat, 32'd32);
    check_output("sra31_out", out, 32'hFFFF_FFFF);

    apply_stimulus(2'b01, 32'h8000_0000, 5'd31);
    wait_done(1, lat, busy_cnt);
    check_output("srl31_out", out, 32'h0000_0001);

    apply_stimulus(2'b00, 32'h0000_0001, 5'd31);
    wait_done(1, lat, busy_cnt);
    check_output("sll31_out", out, 32'h8000_0000);

    apply_stimulus(2'b11, 32'h8000_0001, 5'd31);
    wait_done(1, lat, busy_cnt);
    check_output("ror31_out", out, 32'h0000_0003);

    // A start pulse mid-operation must not disturb the running shift
    apply_stimulus(2'b00, 32'h0000_0003, 5'd6);
    start   = 1'b1;
    op      = 2'b11;
    in_data = 32'hDEAD_BEEF;
    in_n    = 5'd1;
    @(negedge clk);
    start   = 1'b0;
    @(negedge clk);
    wait_done(3, lat, busy_cnt);
    check_output("busy_start_latency", lat, 32'd7);
    check_output("busy_start_out", out, 32'h0000_00C0);

    apply_stimulus(2'b01, 32'hDEAD_BEEF, 5'd4);
    wait_done(1, lat, busy_cnt);
    check_output("after_busy_latency", lat, 32'd5);
    check_output("after_busy_out", out, 32'h0DEA_DBEE);

    // Reset four cycles into a 10-bit SLL aborts it with no later done pulse
    apply_stimulus(2'b00, 32'h0000_0001, 5'd10);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("abort_out", out, 32'h0);
    check_output("abort_busy", {31'b0, busy}, 32'h0);
    check_output("abort_done", {31'b0, done}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    check_output("abort_no_done", done_cnt, 32'd0);
    check_output("abort_no_busy", busy_cnt, 32'd0);
    check_output("abort_out_held", out, 32'h0);

    apply_stimulus(2'b00, 32'h0000_0001, 5'd10);
    wait_done(1, lat, busy_cnt);
    check_output("post_abort_latency", lat, 32'd11);
    check_output("post_abort_out", out, 32'h0000_0400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
